// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one AXI-lite master among NUM_REQ requesters.
// Optional response timeout enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_lite_req_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      start_read,
    output logic                      start_write,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         data,
    input  logic                      awvalid,
    input  logic                      awready,
    input  logic                      arvalid,
    input  logic                      arready,
    input  logic                      bvalid,
    input  logic                      bready,
    input  logic                      rvalid,
    input  logic                      rready,
    input  logic [1:0]                bresp,
    input  logic [1:0]                rresp,
    input  logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    logic                req_any;
    logic [IDX_W-1:0]    arb_idx;
    int unsigned         cand;

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
`else
    logic [31:0]         unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        req_any = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!req_any && req_valid[cand[IDX_W-1:0]]) begin
                req_any = 1'b1;
                arb_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
`ifdef AXI_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
`ifdef AXI_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = ISSUE;
                    gnt_d   = arb_idx;
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    write_d = req_write[arb_idx];
                    addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[arb_idx*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                if (write_q ? (awvalid && awready) : (arvalid && arready)) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (write_q && bvalid && bready) begin
                    resp_d  = bresp;
                    rdata_d = '0;
                    state_d = RESPOND;
                end else if (!write_q && rvalid && rready) begin
                    resp_d  = rresp;
                    rdata_d = rdata;
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef AXI_ARB_TIMEOUT_EN
        // Counter restarts on every state change; expiry forces an SLVERR response.
        if ((state_q == ISSUE || state_q == WAIT_RESP) && state_d == state_q) begin
            if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = RESPOND;
                resp_d  = 2'b10;
                rdata_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        // Grant pulse is combinational on req_valid, so keep it quiet during reset.
        if (state_q == IDLE && req_any && areset_n) begin
            req_ready[arb_idx] = 1'b1;
        end
        if (state_q == RESPOND) begin
            rsp_valid[gnt_q] = 1'b1;
        end
        start_write = (state_q == ISSUE) && write_q;
        start_read  = (state_q == ISSUE) && !write_q;
        addr        = addr_q;
        data        = wdata_q;
        rsp_rdata   = rdata_q;
        rsp_resp    = resp_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Self-checking bench for axi_lite_req_arbiter: directed tests plus randomized
// traffic against a queue/array level reference model; the bench plays the bus.
module tb_axi_lite_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 256;
`endif

    logic              aclk;
    logic              areset_n;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_rdata, data, rdata;
    logic [1:0]        rsp_resp, bresp, rresp;
    logic              start_read, start_write, busy;
    logic [AW-1:0]     addr;
    logic              awvalid, awready, arvalid, arready, bvalid, bready, rvalid, rready;

    axi_lite_req_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .start_read(start_read), .start_write(start_write), .addr(addr), .data(data),
        .awvalid(awvalid), .awready(awready), .arvalid(arvalid), .arready(arready),
        .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready),
        .bresp(bresp), .rresp(rresp), .rdata(rdata), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: pending request table, round-robin pointer, memory image.
    bit          pend [NR];
    bit          pw   [NR];
    logic [31:0] pa   [NR];
    logic [31:0] pd   [NR];
    int          wait_cnt [NR];
    int          ptr;
    logic [31:0] mem [bit [31:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_start"}, {start_read, start_write}, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_resp"}, rsp_resp, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        pend[i] = 1'b1; pw[i] = w; pa[i] = a; pd[i] = d; wait_cnt[i] = 0;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < NR; k++) begin
            if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic clear_bus();
        awvalid = 0; awready = 0; arvalid = 0; arready = 0;
        bvalid = 0; bready = 0; rvalid = 0; rready = 0;
    endtask

    // Called at a negedge (plus settle) in IDLE with requests pending; returns at the next IDLE negedge.
    task automatic serve(input int aw_dly, input int rsp_dly, input bit wrong, output int g);
        logic [NR-1:0] oh;
        logic [31:0]   erd;
        logic [1:0]    rc;
        g  = exp_grant();
        oh = '0;
        oh[g] = 1'b1;
        chk("req_ready_grant", req_ready, oh);
        chk("busy_idle", busy, 0);
        chk("no_starve", wait_cnt[g] < NR, 1);
        for (int i = 0; i < NR; i++) if (pend[i] && i != g) wait_cnt[i]++;
        @(negedge aclk);
        req_valid[g] = 1'b0;
        pend[g] = 1'b0;
        ptr = (g + 1) % NR;
        chk("req_ready_pulse", req_ready, 0);
        chk("addr_issue", addr, pa[g]);
        if (pw[g]) chk("data_issue", data, pd[g]);
        for (int k = 0; k <= aw_dly; k++) begin
            chk("start_write", start_write, pw[g]);
            chk("start_read", start_read, !pw[g]);
            chk("busy_issue", busy, 1);
            if (k < aw_dly && wrong) begin
                if (pw[g]) begin arvalid = 1; arready = 1; end
                else       begin awvalid = 1; awready = 1; end
            end else if (k == aw_dly) begin
                if (pw[g]) begin awvalid = 1; awready = 1; end
                else       begin arvalid = 1; arready = 1; end
            end
            @(negedge aclk);
            clear_bus();
        end
        chk("start_off_wait", {start_read, start_write}, 0);
        chk("addr_hold", addr, pa[g]);
        for (int k = 0; k < rsp_dly; k++) begin
            if (wrong) begin
                if (pw[g]) begin rvalid = 1; rready = 1; rdata = $urandom; rresp = 2'b01; end
                else       begin bvalid = 1; bready = 1; bresp = 2'b01; end
            end
            @(negedge aclk);
            clear_bus();
            chk("rsp_early", rsp_valid, 0);
        end
        rc = 2'($urandom_range(3));
        if (pw[g]) begin
            mem[pa[g]] = pd[g];
            erd = '0;
            bvalid = 1; bready = 1; bresp = rc;
            rdata = $urandom;
        end else begin
            erd = mem.exists(pa[g]) ? mem[pa[g]] : 32'h0;
            rvalid = 1; rready = 1; rdata = erd; rresp = rc;
        end
        @(negedge aclk);
        clear_bus();
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_resp", rsp_resp, rc);
        @(negedge aclk);
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_rdata_hold", rsp_rdata, erd);
        chk("rsp_resp_hold", rsp_resp, rc);
    endtask

    initial begin
        int g;
        areset_n = 0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        clear_bus();
        bresp = 0; rresp = 0; rdata = 0;
        ptr = 0;
        for (int i = 0; i < NR; i++) begin pend[i] = 0; wait_cnt[i] = 0; end

        repeat (3) @(negedge aclk);
        req_valid = '1;
        #1;
        chk_all_zero("reset");
        req_valid = '0;
        @(negedge aclk);
        areset_n = 1;
        @(negedge aclk);

        // Write then read back through different requesters.
        set_req(0, 1, 32'h2, 32'hdeadbeef); #1;
        serve(2, 1, 1, g);
        chk("t1_resp", rsp_resp !== 2'bxx, 1);
        set_req(1, 0, 32'h2, 32'h0); #1;
        serve(0, 0, 0, g);
        chk("t2_rdata", rsp_rdata, 32'hdeadbeef);

        // Reset while waiting for the write response aborts silently.
        set_req(2, 1, 32'h10, 32'h55); #1;
        @(negedge aclk);
        req_valid[2] = 0; pend[2] = 0;
        awvalid = 1; awready = 1;
        @(negedge aclk);
        clear_bus();
        chk("t5_busy", busy, 1);
        areset_n = 0;
        #1;
        chk_all_zero("t5_async");
        ptr = 0;
        @(negedge aclk);
        areset_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("t5_no_rsp", {rsp_valid, busy}, 0);
        end

        // All four at once from pointer 0.
        set_req(0, 1, 32'h1, 32'ha);
        set_req(1, 1, 32'h2, 32'h11);
        set_req(2, 1, 32'h3, 32'h10);
        set_req(3, 1, 32'h4, 32'hc1);
        #1;
        for (int k = 0; k < NR; k++) begin
            serve(k % 2, 1, 0, g);
            chk("t3_order", g, k);
        end
        set_req(0, 0, 32'h4, 32'h0); #1;
        serve(1, 2, 1, g);
        chk("t3_readback", rsp_rdata, 32'hc1);

        // Pointer at 2 with requesters 0 and 3 waiting.
        set_req(1, 0, 32'h1, 32'h0); #1;
        serve(0, 0, 0, g);
        set_req(0, 1, 32'h5, 32'h77);
        set_req(3, 1, 32'h6, 32'h88);
        #1;
        serve(0, 0, 0, g);
        chk("t4_first", g, 3);
        serve(0, 0, 0, g);
        chk("t4_second", g, 0);

        // Randomized traffic, small address space so reads hit earlier writes.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(1) == 1)
                    set_req(i, 1'($urandom_range(1)), 32'($urandom_range(7)), $urandom);
            end
            if (exp_grant() < 0) set_req(it % NR, 0, 32'($urandom_range(7)), 32'h0);
            #1;
            serve(int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)), g);
        end
        while (exp_grant() >= 0) begin
            #1;
            serve(0, 0, 0, g);
        end

`ifdef AXI_ARB_TIMEOUT_EN
        // AW handshake never arrives.
        set_req(ptr, 1, 32'h20, 32'h1); #1;
        g = ptr;
        @(negedge aclk);
        req_valid[g] = 0; pend[g] = 0; ptr = (g + 1) % NR;
        for (int k = 0; k < TMO; k++) begin
            chk("tmo_issue_hold", {rsp_valid == 0, start_write}, 2'b11);
            @(negedge aclk);
        end
        chk("tmo_issue_rsp", rsp_valid[g], 1);
        chk("tmo_issue_resp", rsp_resp, 2'b10);
        chk("tmo_issue_rdata", rsp_rdata, 0);
        chk("tmo_issue_start", {start_read, start_write}, 0);
        @(negedge aclk);
        // Read accepted, response never arrives.
        set_req(ptr, 0, 32'h3, 32'h0); #1;
        g = ptr;
        @(negedge aclk);
        req_valid[g] = 0; pend[g] = 0; ptr = (g + 1) % NR;
        arvalid = 1; arready = 1;
        @(negedge aclk);
        clear_bus();
        for (int k = 0; k < TMO; k++) begin
            chk("tmo_wait_hold", rsp_valid, 0);
            @(negedge aclk);
        end
        chk("tmo_wait_rsp", rsp_valid[g], 1);
        chk("tmo_wait_resp", rsp_resp, 2'b10);
        chk("tmo_wait_rdata", rsp_rdata, 0);
        @(negedge aclk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one axi_lite_master among NUM_REQ local requesters.
- Accepts one read or write request at a time and drives the master's start_read/start_write/addr/data.
- Tracks the transaction on the AXI-lite bus through to its response, then returns read data and response to the winning requester.
- Sits between client logic and the master; the slave side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width (matches addr_t)
DATA_W, 32, data width (matches data_t)
TIMEOUT_CYCLES, 256, response timeout in aclk cycles (used only with the optional feature)

Ports:
aclk  in  1  clock, rising edge
areset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request, level, held until req_ready
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: transaction complete
rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes)
rsp_resp  out  2  bresp/rresp, valid with rsp_valid
start_read  out  1  to master
start_write  out  1  to master
addr  out  ADDR_W  to master
data  out  DATA_W  to master
awvalid, awready, arvalid, arready, bvalid, bready, rvalid, rready  in  1 each  bus monitor taps
bresp, rresp  in  2 each  bus monitor taps
rdata  in  DATA_W  bus monitor tap
busy  out  1  high in any state other than IDLE

Behaviour:
Reset (async assert, sync deassert is the integrator's responsibility):
- All outputs 0; state IDLE; round-robin pointer = 0; internal latches cleared.
- Reset mid-transaction aborts silently: no rsp_valid is issued.

FSM states: IDLE, ISSUE, WAIT_RESP, RESPOND.

IDLE:
- If any req_valid is set, grant the first set bit searching upward from pointer, wrapping modulo NUM_REQ.
- In the same cycle: pulse req_ready[g], latch write/addr/wdata and grant index g, go to ISSUE.
- Pointer becomes (g+1) mod NUM_REQ.
- Requester must drop req_valid after req_ready or it re-enters arbitration.

ISSUE:
- Drive addr/data from the latches; assert start_write (write) or start_read (read).
- Hold until the handshake is seen: awvalid&awready for writes, arvalid&arready for reads. Then deassert start_*, go to WAIT_RESP.
- addr/data stay held until RESPOND.

WAIT_RESP:
- Writes: on bvalid&bready, capture bresp, set rdata latch to 0.
- Reads: on rvalid&rready, capture rdata/rresp.
- Then go to RESPOND.
- Bus traffic of the wrong type is ignored.

RESPOND:
- One cycle: rsp_valid[g]=1 with rsp_rdata/rsp_resp; then IDLE.
- rsp_rdata/rsp_resp hold their last value until the next RESPOND.

Timing and boundaries:
- Minimum latency req_valid to rsp_valid = 4 cycles plus bus latency. Back-to-back grants: 1 IDLE cycle between transactions.
- start_read and start_write are never asserted together.
- Addresses are forwarded unchecked; X/invalid addresses propagate, with no decode in this block.
- A request arriving while busy waits. No starvation: each waiting requester is served within NUM_REQ grants.
- Single requester: served every transaction.

Optional Feature:
Macro AXI_ARB_TIMEOUT_EN.
- Defined: a counter runs in ISSUE and WAIT_RESP, cleared on state entry. On reaching TIMEOUT_CYCLES-1, go to RESPOND with rsp_resp=2'b10 (SLVERR), rsp_rdata=0, and start_* deasserted.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
1. Reset, then req 0 writes addr 0x2, data 0xdeadbeef → start_write held until AW handshake; rsp_valid[0] pulse, rsp_resp=0, rsp_rdata=0.
2. Req 1 reads addr 0x2 after test 1 → start_read asserted, rsp_rdata=0xdeadbeef, rsp_valid[1].
3. Req 0–3 all valid at once (writes to 0x1–0x4, data 0xa/0x11/0x10/0xc1) → grant order 0,1,2,3; four rsp pulses in that order; readback of 0x4 = 0xc1.
4. Pointer=2, req 0 and req 3 valid → req 3 granted first, then 0.
5. areset_n low during WAIT_RESP → all outputs 0 immediately; no rsp_valid; next request is served normally.
6. With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts bvalid → rsp_valid 16 cycles after ISSUE entry, rsp_resp=2'b10.
